// File: rtl/apb_local_bridge.sv
// APB completer that forwards each transfer as one req/ack transaction on a local register bus.
// Local acknowledge latency becomes APB wait states; a missing acknowledge times out to PSLVERR.
module apb_local_bridge #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              loc_req,
    output logic              loc_write,
    output logic [ADDR_W-1:0] loc_addr,
    output logic [DATA_W-1:0] loc_wdata,
    input  logic              loc_ack,
    input  logic [DATA_W-1:0] loc_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            loc_req   <= 1'b0;
            loc_write <= 1'b0;
            loc_addr  <= '0;
            loc_wdata <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (PSEL && !PENABLE) begin
                        loc_write <= PWRITE;
                        loc_addr  <= PADDR;
                        loc_wdata <= PWDATA;
                        loc_req   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // An acknowledge on the timeout edge still counts as a normal completion.
                    if (loc_ack) begin
                        loc_req <= 1'b0;
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b0;
                        if (!loc_write) begin
                            PRDATA <= loc_rdata;
                        end
                        state_q <= StResp;
                    end else if (cnt_q == CNT_LAST) begin
                        loc_req <= 1'b0;
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b1;
                        if (!loc_write) begin
                            PRDATA <= '0;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
